// File: rtl/uart_tx_frame_gen_if.sv
// Host-side word handshake for uart_tx_frame_gen.
// A word moves on a rising clk edge where data_valid and data_ready are both high. The
// source keeps p_data stable and data_valid high until that edge. data_ready never
// depends on data_valid.
interface uart_tx_frame_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output p_data, output data_valid, input data_ready);
  modport slave  (input p_data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Frame settings and the prescale value are latched when a word is accepted.
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  uart_tx_frame_gen_if.slave        host,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic                      stop_2,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy,
  output logic                      frame_done,
  output logic [2:0]                state_dbg
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t                    state, state_n;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_n, presc_q, presc_in;
  logic [BW-1:0]             bit_idx, bit_n;
  logic [DATA_WIDTH-1:0]     data_sh;
  logic                      par_en_q, stop2_q, par_q;
  logic                      tx_q, tx_n, shift;
  logic                      tick, last_stop, accept;

  assign presc_in        = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign tick            = (cnt == '0);
  assign last_stop       = tick && ((state == STOP1 && !stop2_q) || state == STOP2);
  assign host.data_ready = !rst && (state == IDLE || last_stop);
  assign accept          = host.data_valid && host.data_ready;
  assign frame_done      = last_stop;
  assign busy            = (state != IDLE);
  assign tx_out          = tx_q;
  assign state_dbg       = state;

  always_comb begin
    state_n = state;
    cnt_n   = tick ? presc_q - 1'b1 : cnt - 1'b1;
    bit_n   = bit_idx;
    tx_n    = tx_q;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (accept) begin
          state_n = START;
          cnt_n   = presc_in - 1'b1;
          tx_n    = 1'b0;
        end
      end
      START: if (tick) begin
        state_n = DATA;
        bit_n   = '0;
        tx_n    = data_sh[0];
      end
      DATA: if (tick) begin
        if (bit_idx == LAST_BIT) begin
          state_n = par_en_q ? PARITY : STOP1;
          tx_n    = par_en_q ? par_q : 1'b1;
        end else begin
          bit_n = bit_idx + 1'b1;
          shift = 1'b1;
          tx_n  = data_sh[1];
        end
      end
      PARITY: if (tick) begin
        state_n = STOP1;
        tx_n    = 1'b1;
      end
      STOP1: if (tick && stop2_q) begin
        state_n = STOP2;
        tx_n    = 1'b1;
      end
      STOP2: ;
      default: state_n = IDLE;
    endcase
    // The final stop clock either chains straight into the next start bit or goes idle.
    if (last_stop) begin
      if (accept) begin
        state_n = START;
        cnt_n   = presc_in - 1'b1;
        tx_n    = 1'b0;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      data_sh  <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      presc_q  <= PRESCALE_WIDTH'(1);
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      tx_q    <= tx_n;
      if (accept) begin
        data_sh  <= host.p_data;
        par_en_q <= par_en;
        stop2_q  <= stop_2;
        par_q    <= par_typ ? ~^host.p_data : ^host.p_data;
        presc_q  <= presc_in;
      end else if (shift) begin
        data_sh <= data_sh >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: every clock of each frame is checked against a
// hand-written bit string (start, data LSB first, parity, stop).
module tb_uart_tx_frame_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       par_en, par_typ, stop_2;
  logic [7:0] prescale;
  logic       tx_out, busy, frame_done;
  logic [2:0] state_dbg;

  uart_tx_frame_gen_if #(.DATA_WIDTH(8)) host ();

  uart_tx_frame_gen #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop_2     (stop_2),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  logic tx_a   [0:63];
  logic busy_a [0:63];
  logic done_a [0:63];
  logic rdy_a  [0:63];

  // Present a word with its frame settings; accepted on the next edge if the DUT is ready.
  task automatic setup(input logic [7:0] d, input logic pe, input logic pt,
                       input logic s2, input logic [7:0] p);
    host.p_data     = d;
    host.data_valid = 1'b1;
    par_en          = pe;
    par_typ         = pt;
    stop_2          = s2;
    prescale        = p;
  endtask

  // Record n samples, each taken 1 time unit after a rising edge; sample 0 follows the accepting edge.
  task automatic capture(input int n, input int drop_at, input bit has_next,
                         input logic [7:0] next_word, input bit disturb);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      tx_a[k]   = tx_out;
      busy_a[k] = busy;
      done_a[k] = frame_done;
      rdy_a[k]  = host.data_ready;
      if (k == 0 && has_next) host.p_data = next_word;
      if (k == drop_at) host.data_valid = 1'b0;
      if (disturb && k == 5) begin
        prescale     = 8'd1;
        host.p_data  = ~host.p_data;
        par_en       = ~par_en;
        par_typ      = ~par_typ;
        stop_2       = ~stop_2;
      end
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    host.data_valid = 1'b0;
    host.p_data     = 8'h00;
    par_en          = 1'b0;
    par_typ         = 1'b0;
    stop_2          = 1'b0;
    prescale        = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({tx_out, busy, frame_done, host.data_ready, state_dbg} !== {4'b1000, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state got %b exp %b", {tx_out, busy, frame_done, host.data_ready, state_dbg}, {4'b1000, 3'd0});
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (host.data_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b exp 1", host.data_ready);
    end
  endtask

  task automatic test_parity_even();
    string bits = "01101010111";
    setup(8'hAB, 1'b1, 1'b0, 1'b0, 8'd4);
    capture(45, 0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 44; k++) begin
      logic [2:0] e;
      e = {bits[k/4] == "1", 1'b1, k == 43};
      vectors++;
      if ({tx_a[k], busy_a[k], done_a[k]} !== e) begin
        miscompares++;
        $display("FAIL even_frame clk=%0d got %b exp %b", k, {tx_a[k], busy_a[k], done_a[k]}, e);
      end
    end
    vectors++;
    if ({tx_a[44], busy_a[44], done_a[44]} !== 3'b100) begin
      miscompares++;
      $display("FAIL even_idle got %b exp 100", {tx_a[44], busy_a[44], done_a[44]});
    end
  endtask

  task automatic test_parity_odd_mid_change();
    string bits = "00101010001";
    setup(8'h2A, 1'b1, 1'b1, 1'b0, 8'd3);
    capture(34, 0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 33; k++) begin
      logic [2:0] e;
      e = {bits[k/3] == "1", 1'b1, k == 32};
      vectors++;
      if ({tx_a[k], busy_a[k], done_a[k]} !== e) begin
        miscompares++;
        $display("FAIL odd_frame clk=%0d got %b exp %b", k, {tx_a[k], busy_a[k], done_a[k]}, e);
      end
    end
    vectors++;
    if ({tx_a[33], busy_a[33], done_a[33]} !== 3'b100) begin
      miscompares++;
      $display("FAIL odd_idle got %b exp 100", {tx_a[33], busy_a[33], done_a[33]});
    end
  endtask

  task automatic test_two_stop();
    string bits = "01111100011";
    setup(8'h1F, 1'b0, 1'b0, 1'b1, 8'd2);
    capture(23, 0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 22; k++) begin
      logic [2:0] e;
      e = {bits[k/2] == "1", 1'b1, k == 21};
      vectors++;
      if ({tx_a[k], busy_a[k], done_a[k]} !== e) begin
        miscompares++;
        $display("FAIL two_stop clk=%0d got %b exp %b", k, {tx_a[k], busy_a[k], done_a[k]}, e);
      end
    end
    vectors++;
    if ({tx_a[22], busy_a[22]} !== 2'b10) begin
      miscompares++;
      $display("FAIL two_stop_idle got %b exp 10", {tx_a[22], busy_a[22]});
    end
  endtask

  task automatic test_back_to_back();
    string bits = "01010101010110001011";
    setup(8'h55, 1'b0, 1'b0, 1'b0, 8'd2);
    capture(41, 20, 1'b1, 8'hA3, 1'b0);
    for (int k = 0; k < 40; k++) begin
      logic [3:0] e;
      e = {bits[k/2] == "1", 1'b1, (k % 20) == 19, (k % 20) == 19};
      vectors++;
      if ({tx_a[k], busy_a[k], done_a[k], rdy_a[k]} !== e) begin
        miscompares++;
        $display("FAIL b2b clk=%0d got %b exp %b", k, {tx_a[k], busy_a[k], done_a[k], rdy_a[k]}, e);
      end
    end
    vectors++;
    if ({tx_a[40], busy_a[40], done_a[40], rdy_a[40]} !== 4'b1001) begin
      miscompares++;
      $display("FAIL b2b_idle got %b exp 1001", {tx_a[40], busy_a[40], done_a[40], rdy_a[40]});
    end
  endtask

  task automatic test_reset_mid_frame();
    string bits = "00110100101";
    setup(8'h34, 1'b0, 1'b0, 1'b0, 8'd2);
    capture(9, 0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if ({tx_a[8], busy_a[8]} !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_bit3 got %b exp 01", {tx_a[8], busy_a[8]});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (host.data_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_in_reset got %b exp 0", host.data_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({tx_out, busy, frame_done, host.data_ready, state_dbg} !== {4'b1001, 3'd0}) begin
      miscompares++;
      $display("FAIL mid_reset got %b exp %b", {tx_out, busy, frame_done, host.data_ready, state_dbg}, {4'b1001, 3'd0});
    end
    setup(8'h96, 1'b1, 1'b0, 1'b0, 8'd2);
    capture(23, 0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 22; k++) begin
      logic [2:0] e;
      e = {bits[k/2] == "1", 1'b1, k == 21};
      vectors++;
      if ({tx_a[k], busy_a[k], done_a[k]} !== e) begin
        miscompares++;
        $display("FAIL post_reset clk=%0d got %b exp %b", k, {tx_a[k], busy_a[k], done_a[k]}, e);
      end
    end
  endtask

  task automatic test_prescale_min();
    string bits0 = "00101101001";
    string bits1 = "01100001111";
    setup(8'h5A, 1'b1, 1'b0, 1'b0, 8'd0);
    capture(12, 0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] e;
      e = (k < 11) ? {bits0[k] == "1", 1'b1, k == 10} : 3'b100;
      vectors++;
      if ({tx_a[k], busy_a[k], done_a[k]} !== e) begin
        miscompares++;
        $display("FAIL presc0 clk=%0d got %b exp %b", k, {tx_a[k], busy_a[k], done_a[k]}, e);
      end
    end
    setup(8'hC3, 1'b0, 1'b0, 1'b1, 8'd1);
    capture(12, 0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] e;
      e = (k < 11) ? {bits1[k] == "1", 1'b1, k == 10} : 3'b100;
      vectors++;
      if ({tx_a[k], busy_a[k], done_a[k]} !== e) begin
        miscompares++;
        $display("FAIL presc1 clk=%0d got %b exp %b", k, {tx_a[k], busy_a[k], done_a[k]}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd_mid_change();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_prescale_min();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
